// File: rtl/serial_wb_bridge_if.sv
// Byte-stream UART handshake plus Wishbone master bus of the serial bridge.
// The master modport is the bridge side; the slave modport is the UART/CSR side.
interface serial_wb_bridge_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic [7:0]      rx_dat;
   logic            rx_ready;
   logic            rx_ready_rst;
   logic [7:0]      tx_dat;
   logic            tx_txe;
   logic            tx_busy;
   logic [AW-1:0]   wb_adr_o;
   logic [DW-1:0]   wb_dat_o;
   logic [DW-1:0]   wb_dat_i;
   logic [DW/8-1:0] wb_sel_o;
   logic            wb_we_o;
   logic            wb_stb_o;
   logic            wb_cyc_o;
   logic            wb_ack_i;
   logic            wb_err_i;

   modport master (
      input  rx_dat, rx_ready, tx_busy, wb_dat_i, wb_ack_i, wb_err_i,
      output rx_ready_rst, tx_dat, tx_txe,
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
   );

   modport slave (
      output rx_dat, rx_ready, tx_busy, wb_dat_i, wb_ack_i, wb_err_i,
      input  rx_ready_rst, tx_dat, tx_txe,
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
   );
endinterface

// File: rtl/serial_wb_bridge.sv
// Host-to-Wishbone bridge fed by a UART byte stream.
// Command byte [7]=write, [6]=auto-increment, [5:0]=words-1; then the address
// bytes MSB first, then (writes) the data words MSB first. Every transaction
// closes with a status byte: 0x00 ok, 0x01 bus error, 0x02 timeout. After the
// first error no further bus cycles are issued but the response length and the
// consumed write bytes stay the same, so the host never loses framing.
module serial_wb_bridge #(
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   serial_wb_bridge_if.master bus
);
   localparam int ADDR_BYTES = (AW + 7) / 8;
   localparam int DATA_BYTES = DW / 8;
   localparam int TW         = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ADDR   = 3'd1;
   localparam logic [2:0] WDATA  = 3'd2;
   localparam logic [2:0] WB     = 3'd3;
   localparam logic [2:0] TXDATA = 3'd4;
   localparam logic [2:0] TXSTAT = 3'd5;

   logic [2:0]    state;
   logic          cmd_we;
   logic          cmd_inc;
   logic [5:0]    words_left;
   logic [7:0]    byte_cnt;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic [7:0]    err_code;
   logic [TW-1:0] timer;

   logic          rx_take;
   logic          tx_can;
   logic          last_addr_byte;
   logic          last_data_byte;
   logic          last_word;
   logic [2:0]    word_next_state;

   // Byte handshake qualifiers and end-of-field / end-of-word decodes
   always_comb begin
      rx_take = bus.rx_ready && !bus.rx_ready_rst &&
                (state == IDLE || state == ADDR || state == WDATA);
      // The strobe cycle itself never samples tx_busy, which spaces strobes by two cycles.
      tx_can          = !bus.tx_busy && !bus.tx_txe;
      last_addr_byte  = (byte_cnt == 8'(ADDR_BYTES - 1));
      last_data_byte  = (byte_cnt == 8'(DATA_BYTES - 1));
      last_word       = (words_left == 6'd0);
      word_next_state = last_word ? TXSTAT : (cmd_we ? WDATA : WB);
   end

   // Command parser, bus cycle sequencer and response transmitter
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cmd_we           <= 1'b0;
         cmd_inc          <= 1'b0;
         words_left       <= 6'd0;
         byte_cnt         <= 8'd0;
         addr             <= '0;
         wdata            <= '0;
         rdata            <= '0;
         err_code         <= 8'h00;
         timer            <= '0;
         bus.rx_ready_rst <= 1'b0;
         bus.tx_dat       <= 8'h00;
         bus.tx_txe       <= 1'b0;
         bus.wb_adr_o     <= '0;
         bus.wb_dat_o     <= '0;
         bus.wb_sel_o     <= '0;
         bus.wb_we_o      <= 1'b0;
         bus.wb_stb_o     <= 1'b0;
         bus.wb_cyc_o     <= 1'b0;
      end else begin
         bus.rx_ready_rst <= rx_take;
         bus.tx_txe       <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_take) begin
                  cmd_we     <= bus.rx_dat[7];
                  cmd_inc    <= bus.rx_dat[6];
                  words_left <= bus.rx_dat[5:0];
                  byte_cnt   <= 8'd0;
                  err_code   <= 8'h00;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (rx_take) begin
                  // Shifting keeps only the low AW bits, so excess address bits drop out.
                  addr     <= AW'({addr, bus.rx_dat});
                  byte_cnt <= byte_cnt + 8'd1;
                  if (last_addr_byte) begin
                     byte_cnt <= 8'd0;
                     state    <= cmd_we ? WDATA : WB;
                  end
               end
            end
            WDATA: begin
               if (rx_take) begin
                  wdata    <= DW'({wdata, bus.rx_dat});
                  byte_cnt <= byte_cnt + 8'd1;
                  if (last_data_byte) begin
                     byte_cnt <= 8'd0;
                     state    <= WB;
                  end
               end
            end
            WB: begin
               if (!bus.wb_cyc_o) begin
                  if (err_code != 8'h00) begin
                     // Sticky error: no bus cycle, read word answers with zeros.
                     rdata <= '0;
                     if (cmd_we) begin
                        if (!last_word) begin
                           words_left <= words_left - 6'd1;
                           if (cmd_inc) addr <= addr + AW'(1);
                        end
                        state <= word_next_state;
                     end else begin
                        state <= TXDATA;
                     end
                  end else begin
                     bus.wb_cyc_o <= 1'b1;
                     bus.wb_stb_o <= 1'b1;
                     bus.wb_we_o  <= cmd_we;
                     bus.wb_adr_o <= addr;
                     bus.wb_dat_o <= wdata;
                     bus.wb_sel_o <= '1;
                     timer        <= '0;
                  end
               end else if (bus.wb_err_i || bus.wb_ack_i || timer == TW'(TIMEOUT - 1)) begin
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
                  bus.wb_we_o  <= 1'b0;
                  bus.wb_sel_o <= '0;
                  // err takes priority over a simultaneous ack
                  if (bus.wb_err_i) begin
                     err_code <= 8'h01;
                     rdata    <= '0;
                  end else if (bus.wb_ack_i) begin
                     rdata <= bus.wb_dat_i;
                  end else begin
                     err_code <= 8'h02;
                     rdata    <= '0;
                  end
                  if (cmd_we) begin
                     if (!last_word) begin
                        words_left <= words_left - 6'd1;
                        if (cmd_inc) addr <= addr + AW'(1);
                     end
                     state <= word_next_state;
                  end else begin
                     state <= TXDATA;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            TXDATA: begin
               if (tx_can) begin
                  bus.tx_dat <= rdata[DW-1 -: 8];
                  bus.tx_txe <= 1'b1;
                  rdata      <= rdata << 8;
                  byte_cnt   <= byte_cnt + 8'd1;
                  if (last_data_byte) begin
                     byte_cnt <= 8'd0;
                     if (!last_word) begin
                        words_left <= words_left - 6'd1;
                        if (cmd_inc) addr <= addr + AW'(1);
                     end
                     state <= word_next_state;
                  end
               end
            end
            TXSTAT: begin
               if (tx_can) begin
                  bus.tx_dat <= err_code;
                  bus.tx_txe <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_wb_bridge.sv
// Scoreboard bench for serial_wb_bridge: directed commands push expected TX
// bytes and expected bus cycles; independent monitors pop and compare.
module tb_serial_wb_bridge;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_wb_bridge_if #(.AW(16), .DW(32)) bus ();
   serial_wb_bridge #(.AW(16), .DW(32), .TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [31:0] dat;
      int          dur;
   } bus_exp_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_tx[$];
   bus_exp_t    exp_bus[$];
   logic [7:0]  cmd_q[$];
   int          tx_seen = 0;
   logic        force_busy = 1'b0;
   int          busy_cnt = 0;
   int          slv_mode = 0;   // 0 ack, 1 err, 2 silent
   int          slv_lat = 1;
   logic [31:0] slv_data = 32'h0;
   int          cyc_cnt = 0;
   bus_exp_t    cur;
   logic        cur_valid = 1'b0;
   logic        prev_cyc = 1'b0;
   int          dur = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // TX monitor: every strobe must come while not busy and match the next expected byte
   always @(posedge clk) begin
      #1;
      if (bus.tx_txe === 1'b1) begin
         tx_seen++;
         check("tx_while_busy", {31'd0, bus.tx_busy}, 32'd0);
         if (exp_tx.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL tx_unexpected: got %h expected none", bus.tx_dat);
         end else begin
            check("tx_byte", {24'd0, bus.tx_dat}, {24'd0, exp_tx.pop_front()});
         end
      end
   end

   // UART transmitter model: busy for a few cycles after each strobe, or forced
   always @(posedge clk) begin
      #2;
      if (bus.tx_txe === 1'b1) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = force_busy || (busy_cnt > 0);
   end

   // Wishbone slave model: ack or err in the slv_lat-th cycle of cyc, or never
   always @(posedge clk) begin
      #2;
      if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1) begin
         cyc_cnt++;
         bus.wb_ack_i = (slv_mode == 0 && cyc_cnt == slv_lat);
         bus.wb_err_i = (slv_mode == 1 && cyc_cnt == slv_lat);
         bus.wb_dat_i = (slv_mode == 0 && cyc_cnt == slv_lat) ? slv_data : 32'h0;
         if (slv_mode == 0 && cyc_cnt == slv_lat) slv_data = slv_data + 32'd1;
      end else begin
         cyc_cnt      = 0;
         bus.wb_ack_i = 1'b0;
         bus.wb_err_i = 1'b0;
         bus.wb_dat_i = 32'h0;
      end
   end

   // Bus monitor: check each cycle start against the expected queue and its length
   always @(posedge clk) begin
      #1;
      if (bus.wb_cyc_o === 1'b1) begin
         if (!prev_cyc) begin
            dur = 0;
            if (exp_bus.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL wb_unexpected: got cycle at %h expected none", bus.wb_adr_o);
               cur_valid = 1'b0;
            end else begin
               cur = exp_bus.pop_front();
               cur_valid = 1'b1;
               check("wb_adr", {16'd0, bus.wb_adr_o}, {16'd0, cur.adr});
               check("wb_we", {31'd0, bus.wb_we_o}, {31'd0, cur.we});
               check("wb_sel", {28'd0, bus.wb_sel_o}, 32'h0000000F);
               check("wb_stb", {31'd0, bus.wb_stb_o}, 32'd1);
               if (cur.we) check("wb_dat", bus.wb_dat_o, cur.dat);
            end
         end
         dur++;
      end else if (prev_cyc) begin
         if (cur_valid && cur.dur != 0) check("wb_cyc_len", 32'(dur), 32'(cur.dur));
         cur_valid = 1'b0;
      end
      prev_cyc = (bus.wb_cyc_o === 1'b1);
   end

   task automatic push_bus(input logic we, input logic [15:0] adr, input logic [31:0] dat, input int d);
      bus_exp_t e;
      e.we = we; e.adr = adr; e.dat = dat; e.dur = d;
      exp_bus.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      @(negedge clk);
      bus.rx_dat   = b;
      bus.rx_ready = 1'b1;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (bus.rx_ready_rst !== 1'b1 && k < 2000);
      if (bus.rx_ready_rst !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL rx_consume: got no rx_ready_rst expected pulse for byte %h", b);
      end
      bus.rx_ready = 1'b0;
   endtask

   task automatic send_all();
      while (cmd_q.size() != 0) send_byte(cmd_q.pop_front());
   endtask

   task automatic wait_done();
      int k = 0;
      while ((exp_tx.size() != 0 || exp_bus.size() != 0 || bus.wb_cyc_o === 1'b1) && k < 3000) begin
         @(posedge clk);
         k++;
      end
      if (k >= 3000) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got %0d tx / %0d bus pending expected 0", exp_tx.size(), exp_bus.size());
         exp_tx.delete();
         exp_bus.delete();
      end
      repeat (20) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1;
      bus.rx_dat   = 8'h00;
      bus.rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      check("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
      check("rst_txe", {31'd0, bus.tx_txe}, 32'd0);
      check("rst_rxrst", {31'd0, bus.rx_ready_rst}, 32'd0);
      check("rst_adr", {16'd0, bus.wb_adr_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // single read at 0x1234, ack after 3 cycles
      slv_mode = 0; slv_lat = 3; slv_data = 32'hDEADBEEF;
      push_bus(1'b0, 16'h1234, 32'h0, 3);
      exp_tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
      cmd_q = '{8'h00, 8'h12, 8'h34};
      send_all();
      wait_done();

      // two-word incrementing write
      slv_lat = 1;
      push_bus(1'b1, 16'h0010, 32'h11223344, 1);
      push_bus(1'b1, 16'h0011, 32'h55667788, 1);
      exp_tx = '{8'h00};
      cmd_q = '{8'hC1, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_all();
      wait_done();

      // read timeout
      slv_mode = 2;
      push_bus(1'b0, 16'h0005, 32'h0, 255);
      exp_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
      cmd_q = '{8'h00, 8'h00, 8'h05};
      send_all();
      wait_done();

      // bus error on word 0 of a two-word read: second word is not issued
      slv_mode = 1; slv_lat = 2;
      push_bus(1'b0, 16'hFFFF, 32'h0, 2);
      exp_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      cmd_q = '{8'h41, 8'hFF, 8'hFF};
      send_all();
      wait_done();

      // address wrap 0xFFFF -> 0x0000
      slv_mode = 0; slv_lat = 1; slv_data = 32'h01020304;
      push_bus(1'b0, 16'hFFFF, 32'h0, 1);
      push_bus(1'b0, 16'h0000, 32'h0, 1);
      exp_tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h05, 8'h00};
      cmd_q = '{8'h41, 8'hFF, 8'hFF};
      send_all();
      wait_done();

      // write error on word 0: second word's bytes still consumed, no bus cycle
      slv_mode = 1; slv_lat = 1;
      push_bus(1'b1, 16'h0020, 32'hAABBCCDD, 1);
      exp_tx = '{8'h01};
      cmd_q = '{8'hC1, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h11, 8'h11, 8'h11};
      send_all();
      wait_done();

      // transmitter held busy for 100 cycles mid-response
      slv_mode = 0; slv_lat = 1; slv_data = 32'hA1B2C3D4;
      push_bus(1'b0, 16'h0020, 32'h0, 1);
      push_bus(1'b0, 16'h0021, 32'h0, 1);
      exp_tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD5, 8'h00};
      base = tx_seen;
      cmd_q = '{8'h41, 8'h00, 8'h20};
      send_all();
      for (int k = 0; k < 2000 && tx_seen < base + 3; k++) @(posedge clk);
      #1;
      force_busy = 1'b1;
      @(posedge clk);
      #3;
      base = tx_seen;
      repeat (100) @(posedge clk);
      #3;
      check("busy_hold_no_tx", 32'(tx_seen), 32'(base));
      force_busy = 1'b0;
      wait_done();

      // reset while a read cycle is open, then a fresh read
      slv_mode = 2;
      push_bus(1'b0, 16'h0001, 32'h0, 0);
      cmd_q = '{8'h00, 8'h00, 8'h01};
      send_all();
      for (int k = 0; k < 100 && bus.wb_cyc_o !== 1'b1; k++) @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("pre_rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      check("mid_rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
      check("mid_rst_txe", {31'd0, bus.tx_txe}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      slv_mode = 0; slv_lat = 2; slv_data = 32'hCAFEF00D;
      push_bus(1'b0, 16'h0001, 32'h0, 2);
      exp_tx = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00};
      cmd_q = '{8'h00, 8'h00, 8'h01};
      send_all();
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
